dot_matrix_scanner: RTL and testbench

Downstream consumer of the animation clock generator. Takes the `clk_1kHz` scan strobe plus the `mode`/`pattern` animation state and drives an 8x8 LED dot matrix one row per scan tick. Each full frame is eight ticks long. `mode` and `pattern` are latched only at frame boundaries, so a frame never tears. The block runs entirely in the system `clk` domain; `clk_1kHz` is treated as an asynchronous level input.

---
 rtl/dot_matrix_scanner_if.sv | 22 ++
 rtl/dot_matrix_scanner.sv | 134 +++++++++++++
 tb/tb_dot_matrix_scanner.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dot_matrix_scanner_if.sv
// Scan interface for dot_matrix_scanner: animation inputs toward the scanner,
// row/column drive back toward the LED matrix side.
interface dot_matrix_scanner_if;
  logic       clk_1kHz;
  logic [1:0] mode;
  logic [2:0] pattern;
  logic [7:0] row;
  logic [7:0] col;
  logic       frame_start;

  // Producer of the scan strobe and animation state
  modport master (
    output clk_1kHz, mode, pattern,
    input  row, col, frame_start
  );

  // The scanner itself
  modport slave (
    input  clk_1kHz, mode, pattern,
    output row, col, frame_start
  );
endinterface

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: drives an 8x8 LED matrix one row per rising edge of the
// asynchronous clk_1kHz strobe. mode/pattern are latched only on the tick that
// selects row 0, so a frame never tears.
// Optional feature: define SCAN_BLANK_EN to hold col dark for BLANK_CYCLES
// clk cycles after every row change (anti-ghosting).
module dot_matrix_scanner #(
  parameter int unsigned BLANK_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,   // asynchronous, active-low
  dot_matrix_scanner_if.slave  scan
);

  // Out-of-range blanking length is a build error rather than silent wrap
  if (BLANK_CYCLES == 0 || BLANK_CYCLES > 65535) begin : g_blank_range_bad
    $error("BLANK_CYCLES must be in 1..65535");
  end

  // Column pattern for one row of the current frame
  function automatic logic [7:0] col_data(input logic [1:0] m,
                                          input logic [2:0] p,
                                          input logic [2:0] r);
    logic [2:0] pos;
    logic [7:0] d;
    pos = r + p;  // 3-bit sum wraps mod 8 by construction
    case (m)
      2'd0, 2'd1: d = 8'b1 << pos;
      2'd2:       d = 8'h18;
      default:    d = 8'h00;
    endcase
    return d;
  endfunction

  logic       sync1_reg, sync2_reg, prev_reg;
  logic       tick;
  logic [2:0] row_idx_reg, row_idx_next;
  logic       fresh_reg;
  logic [1:0] f_mode_reg;
  logic [2:0] f_pat_reg;
  logic       frame_tick;
  logic [7:0] row_reg, col_reg;
  logic       frame_start_reg;

  // Two-flop synchronizer plus edge register on the scan strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= scan.clk_1kHz;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign tick = sync2_reg & ~prev_reg;

  // The first tick after reset always lands on row 0
  assign row_idx_next = fresh_reg ? 3'd0 : row_idx_reg + 3'd1;
  assign frame_tick   = tick && (row_idx_next == 3'd0);

  // Row index, fresh flag and frame-boundary latch of mode/pattern
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx_reg <= 3'd0;
      fresh_reg   <= 1'b1;
      f_mode_reg  <= 2'd0;
      f_pat_reg   <= 3'd0;
    end else if (tick) begin
      row_idx_reg <= row_idx_next;
      fresh_reg   <= 1'b0;
      if (frame_tick) begin
        f_mode_reg <= scan.mode;
        f_pat_reg  <= scan.pattern;
      end
    end
  end

  // Registered row select and frame marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg         <= 8'h00;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_tick;
      if (tick) begin
        row_reg <= 8'b1 << row_idx_next;
      end
    end
  end

`ifdef SCAN_BLANK_EN
  logic [15:0] blank_cnt_reg;

  // Blank col after each row change; reveal the row data once the count expires.
  // Loading on the 1->0 step gives exactly BLANK_CYCLES dark cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg       <= 8'h00;
      blank_cnt_reg <= 16'd0;
    end else if (tick) begin
      col_reg       <= 8'h00;
      blank_cnt_reg <= 16'(BLANK_CYCLES);
    end else if (blank_cnt_reg != 16'd0) begin
      blank_cnt_reg <= blank_cnt_reg - 16'd1;
      if (blank_cnt_reg == 16'd1) begin
        col_reg <= col_data(f_mode_reg, f_pat_reg, row_idx_reg);
      end
    end
  end
`else
  logic [1:0] eff_mode;
  logic [2:0] eff_pat;

  // On a row-0 tick the freshly latched values are bypassed straight into col
  assign eff_mode = frame_tick ? scan.mode    : f_mode_reg;
  assign eff_pat  = frame_tick ? scan.pattern : f_pat_reg;

  // Column data updates on the same edge as row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg <= 8'h00;
    end else if (tick) begin
      col_reg <= col_data(eff_mode, eff_pat, row_idx_next);
    end
  end
`endif

  assign scan.row         = row_reg;
  assign scan.col         = col_reg;
  assign scan.frame_start = frame_start_reg;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench for dot_matrix_scanner: each strobe pushes the expected
// row update; a negedge monitor pops and compares whenever row changes.
module tb_dot_matrix_scanner;

  localparam int BLANK = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
    logic       fs;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] prev_row;
  logic [7:0] rows_seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  dot_matrix_scanner_if dif ();

  dot_matrix_scanner #(.BLANK_CYCLES(BLANK)) dut (
    .clk  (clk),
    .rst  (rst),
    .scan (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every row change is one DUT transaction
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_row = dif.row;
    end else if (dif.row !== prev_row) begin
      prev_row = dif.row;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: row=%02h col=%02h with nothing pending", dif.row, dif.col);
      end else begin
        e = sb.pop_front();
        $display("update cyc=%0d row=%02h col=%02h fs=%0b (exp row=%02h col=%02h fs=%0b cyc=%0d)",
                 cyc, dif.row, dif.col, dif.frame_start, e.row, e.col, e.fs, e.cyc);
        check("row", 32'(dif.row), 32'(e.row));
        check("col", 32'(dif.col), 32'(e.col));
        check("frame_start", 32'(dif.frame_start), 32'(e.fs));
        check("update_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("frame_start_idle", 32'(dif.frame_start), 32'd0);
    end
  end

  // One strobe; m/p are applied off negedges after the rise (0 = before it)
  task automatic step(input logic [1:0] m, input logic [2:0] p,
                      input logic [7:0] r, input logic [7:0] c, input int off);
    exp_t e;
    int   c0;
    int   gap;
    @(negedge clk);
    c0 = cyc;
    e.row = r;
    e.fs  = (r == 8'h01);
    e.cyc = c0 + 3;
`ifdef SCAN_BLANK_EN
    e.col = 8'h00;
    gap   = BLANK + 8;
`else
    e.col = c;
    gap   = 8;
`endif
    sb.push_back(e);
    if (off == 0) begin
      dif.mode    = m;
      dif.pattern = p;
    end
    dif.clk_1kHz = 1'b1;
    for (int k = 1; k <= gap; k++) begin
      @(negedge clk);
      if (k == off) begin
        dif.mode    = m;
        dif.pattern = p;
      end
      if (k == 3) dif.clk_1kHz = 1'b0;
`ifdef SCAN_BLANK_EN
      if (k == 3 + BLANK - 1) check("col_blank_last", 32'(dif.col), 32'd0);
      if (k == 3 + BLANK)     check("col_after_blank", 32'(dif.col), 32'(c));
`endif
    end
    $display("step row=%02h col=%02h mode=%0d pattern=%0d done", r, c, m, p);
  endtask

`ifdef SCAN_BLANK_EN
  // Second strobe lands 10 cycles into the first row's blanking window
  task automatic restart(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] c2);
    exp_t e;
    int   c0;
    @(negedge clk);
    c0 = cyc;
    e.col = 8'h00;
    e.row = r1; e.fs = (r1 == 8'h01); e.cyc = c0 + 3;
    sb.push_back(e);
    e.row = r2; e.fs = (r2 == 8'h01); e.cyc = c0 + 13;
    sb.push_back(e);
    dif.clk_1kHz = 1'b1;
    for (int k = 1; k <= 13 + BLANK + 5; k++) begin
      @(negedge clk);
      if (k == 3 || k == 13) dif.clk_1kHz = 1'b0;
      if (k == 10) dif.clk_1kHz = 1'b1;
      if (k == 12) check("col_dark_before_restart", 32'(dif.col), 32'd0);
      if (k == 13 + BLANK - 1) check("col_restart_blank_last", 32'(dif.col), 32'd0);
      if (k == 13 + BLANK)     check("col_restart_after", 32'(dif.col), 32'(c2));
    end
    $display("restart rows %02h->%02h col=%02h done", r1, r2, c2);
  endtask
`endif

  initial begin
    dif.clk_1kHz = 1'b0;
    dif.mode     = 2'd0;
    dif.pattern  = 3'd0;

    // Reset, then stay dark with no strobe
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_row", 32'(dif.row), 32'd0);
    check("idle_col", 32'(dif.col), 32'd0);
    check("idle_fs", 32'(dif.frame_start), 32'd0);

    // First tick, scan and wrap
    step(0, 0, 8'h01, 8'h01, 0);
    step(0, 0, 8'h02, 8'h02, 0);
    step(0, 0, 8'h04, 8'h04, 0);
    step(0, 0, 8'h08, 8'h08, 0);
    step(0, 0, 8'h10, 8'h10, 0);
    step(0, 0, 8'h20, 8'h20, 0);
    step(0, 0, 8'h40, 8'h40, 0);
    step(0, 0, 8'h80, 8'h80, 0);
    step(0, 0, 8'h01, 8'h01, 0);

    // Pattern change mid-frame only shows from the next row 0
    step(0, 0, 8'h02, 8'h02, 0);
    step(0, 0, 8'h04, 8'h04, 0);
    step(0, 0, 8'h08, 8'h08, 0);
    step(0, 0, 8'h10, 8'h10, 0);
    step(0, 3, 8'h20, 8'h20, 0);
    step(0, 3, 8'h40, 8'h40, 0);
    step(0, 3, 8'h80, 8'h80, 0);
    step(0, 3, 8'h01, 8'h08, 0);
    step(0, 3, 8'h02, 8'h10, 0);
    step(0, 3, 8'h04, 8'h20, 0);
    step(0, 3, 8'h08, 8'h40, 0);
    step(0, 3, 8'h10, 8'h80, 0);
    step(0, 3, 8'h20, 8'h01, 0);
    step(0, 3, 8'h40, 8'h02, 0);
    step(0, 3, 8'h80, 8'h04, 0);

    // Stop bar, then off (row keeps scanning)
    for (int i = 0; i < 8; i++) step(2, 3, rows_seq[i], 8'h18, 0);
    for (int i = 0; i < 8; i++) step(3, 3, rows_seq[i], 8'h00, 0);

    // Change in the tick cycle is captured
    step(1, 7, 8'h01, 8'h80, 2);
    step(1, 7, 8'h02, 8'h01, 0);

    // Asynchronous reset mid-scan
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_row", 32'(dif.row), 32'd0);
    check("rst_col", 32'(dif.col), 32'd0);
    check("rst_fs", 32'(dif.frame_start), 32'd0);
    dif.mode    = 2'd0;
    dif.pattern = 3'd5;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_row", 32'(dif.row), 32'd0);
    check("post_rst_col", 32'(dif.col), 32'd0);
    check("post_rst_fs", 32'(dif.frame_start), 32'd0);

    // Restart at row 0; a change one cycle after the tick is not captured
    step(0, 2, 8'h01, 8'h20, 3);
    step(0, 2, 8'h02, 8'h40, 0);

`ifdef SCAN_BLANK_EN
    dif.pattern = 3'd5;
    restart(8'h04, 8'h08, 8'h01);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
